brew_sequencer: RTL and testbench
=================================

Name: brew_sequencer

Overview:
- Timed dispensing controller for the coffee machine.
- Takes the 2-bit drink mode (M1,M0) from the ingredient-decode stage plus a user start pulse, then drives the water, coffee and milk valves through fixed-length phases.
- Reports busy/done status and fault conditions back to the front panel.

Parameters:
WATER_CYCLES, 8, clock cycles the water valve stays open (must be >= 1)
COFFEE_CYCLES, 6, clock cycles the coffee valve stays open (must be >= 1)
MILK_CYCLES, 4, clock cycles the milk valve stays open (must be >= 1)
CNT_W, 8, phase counter width; every *_CYCLES value must be <= 2**CNT_W

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset (sampled on rising clk edge when 0)
start  input  1  request to brew; sampled only in IDLE
cancel  input  1  abort current brew
mode  input  2  drink code {M1,M0}: 00 none, 01 black, 10 milk wanted but unavailable, 11 with milk
valve_agua  output  1  water valve open
valve_cafe  output  1  coffee valve open
valve_leche  output  1  milk valve open
busy  output  1  sequence in progress
done  output  1  one-cycle pulse, brew completed
fault  output  1  one-cycle pulse, start with mode 00
no_milk  output  1  sticky flag, brew ran without requested milk

Behaviour:
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- Reset (reset==0 at a clk edge): state IDLE, counter 0, latched mode 00, all outputs 0 from that edge. Reset overrides start and cancel and may hit mid-brew; valves close on that same edge.
- States: IDLE, WATER, COFFEE, MILK, FINISH.
- IDLE, start=1, mode!=00:
  - latch mode, load counter with WATER_CYCLES-1, go to WATER.
  - no_milk <= (mode==10); otherwise no_milk clears on this edge.
- IDLE, start=1, mode==00: fault=1 for exactly one cycle, stay in IDLE.
- IDLE, start=0: hold.
- WATER: valve_agua=1, busy=1. Counter decrements each cycle; when it is 0, load COFFEE_CYCLES-1 and go to COFFEE.
- COFFEE: valve_cafe=1, busy=1. When counter is 0:
  - latched mode 11: load MILK_CYCLES-1, go to MILK.
  - otherwise: go to FINISH.
- MILK: valve_leche=1, busy=1. When counter is 0, go to FINISH.
- FINISH: done=1, busy=1, all valves 0. Next state is IDLE unconditionally.
- Exactly one valve is open at any cycle; phases are contiguous with no gap cycle between them.
- Timing, start sampled at edge 0 (cycle n = the cycle after edge n):
  - Water open cycles 1..W.
  - Coffee open cycles W+1..W+C.
  - Milk open cycles W+C+1..W+C+M (mode 11 only).
  - done on the following cycle.
  - busy high from cycle 1 through the done cycle inclusive.
- start while busy is ignored, not queued. mode changes after latching are ignored.
- cancel=1 in WATER/COFFEE/MILK: next edge goes to IDLE with all valves 0, busy 0, no done pulse. no_milk is kept.
- cancel in IDLE or FINISH has no effect (FINISH still pulses done).
- cancel and start in the same IDLE cycle: start wins (cancel only acts when busy).
- Counter never wraps: it is loaded only on phase entry and only compared to 0.
- Illegal/unreached state encoding recovers to IDLE with all outputs 0.

Decomposition:
- Package brew_pkg:
  - state enum brew_state_t (IDLE, WATER, COFFEE, MILK, FINISH).
  - mode constants MODE_NONE=2'b00, MODE_BLACK=2'b01, MODE_NOMILK=2'b10, MODE_MILK=2'b11.
- One sub-module, phase_timer: CNT_W-bit down counter with load, load value, and expired (count==0) output, used for all three phases.

Test Plan:
- Mode 01 black, defaults: start pulse at edge 0 -> valve_agua cycles 1-8, valve_cafe 9-14, done at 15, busy 1-15, valve_leche never high, no_milk 0.
- Mode 11 with milk: start -> agua 1-8, cafe 9-14, leche 15-18, done at 19, busy 1-19.
- Mode 10: start -> same timing as mode 01 (done at 15); no_milk=1 from cycle 1 and stays 1 after done until next start with mode 01, where it clears.
- Mode 00 start -> fault high for exactly one cycle, busy/valves stay 0; a second start with mode 01 then brews normally.
- cancel asserted at cycle 10 (coffee phase) -> cycle 11 all valves 0, busy 0, done never pulses. start asserted at cycle 5 of any brew is ignored (done timing unchanged).
- reset=0 for one edge at cycle 16 of a mode-11 brew -> outputs all 0 from the next cycle, state IDLE. Also sweep WATER_CYCLES=COFFEE_CYCLES=MILK_CYCLES=1 -> agua 1, cafe 2, leche 3, done 4.

Source files
------------

// File: rtl/brew_pkg.sv
// Shared types and constants for the brew sequencer: FSM state encoding and drink mode codes.
package brew_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WATER  = 3'd1,
      COFFEE = 3'd2,
      MILK   = 3'd3,
      FINISH = 3'd4
   } brew_state_t;

   localparam logic [1:0] MODE_NONE   = 2'b00;
   localparam logic [1:0] MODE_BLACK  = 2'b01;
   localparam logic [1:0] MODE_NOMILK = 2'b10;
   localparam logic [1:0] MODE_MILK   = 2'b11;

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter shared by all dispensing phases; expired flags a zero count.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   // Saturates at zero so a stray decrement can never wrap into a long phase.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/brew_sequencer.sv
// Timed valve sequencer: water, coffee, optional milk, then a one-cycle done pulse.
module brew_sequencer
   import brew_pkg::*;
#(
   parameter int unsigned WATER_CYCLES  = 8,
   parameter int unsigned COFFEE_CYCLES = 6,
   parameter int unsigned MILK_CYCLES   = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       cancel,
   input  logic [1:0] mode,
   output logic       valve_agua,
   output logic       valve_cafe,
   output logic       valve_leche,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic       no_milk
);

   localparam logic [CNT_W-1:0] WATER_LOAD  = CNT_W'(WATER_CYCLES - 1);
   localparam logic [CNT_W-1:0] COFFEE_LOAD = CNT_W'(COFFEE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MILK_LOAD   = CNT_W'(MILK_CYCLES - 1);

   brew_state_t state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic        no_milk_q, no_milk_d;

   logic agua_q, agua_d;
   logic cafe_q, cafe_d;
   logic leche_q, leche_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic fault_q, fault_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_dec;
   logic             tmr_expired;

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .expired  (tmr_expired)
   );

   // Outputs are decoded from the current state and registered, so they trail the state by
   // one edge; cancel is folded in here so the valves close on the very edge that sees it.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      no_milk_d = no_milk_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_dec   = 1'b0;
      agua_d    = 1'b0;
      cafe_d    = 1'b0;
      leche_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      fault_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (mode != MODE_NONE) begin
                  mode_d    = mode;
                  no_milk_d = (mode == MODE_NOMILK);
                  tmr_load  = 1'b1;
                  tmr_val   = WATER_LOAD;
                  state_d   = WATER;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         WATER: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               agua_d = 1'b1;
               busy_d = 1'b1;
               if (tmr_expired) begin
                  tmr_load = 1'b1;
                  tmr_val  = COFFEE_LOAD;
                  state_d  = COFFEE;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         COFFEE: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               cafe_d = 1'b1;
               busy_d = 1'b1;
               if (tmr_expired) begin
                  if (mode_q == MODE_MILK) begin
                     tmr_load = 1'b1;
                     tmr_val  = MILK_LOAD;
                     state_d  = MILK;
                  end else begin
                     state_d = FINISH;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         MILK: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               leche_d = 1'b1;
               busy_d  = 1'b1;
               if (tmr_expired) begin
                  state_d = FINISH;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         mode_q    <= MODE_NONE;
         no_milk_q <= 1'b0;
         agua_q    <= 1'b0;
         cafe_q    <= 1'b0;
         leche_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         no_milk_q <= no_milk_d;
         agua_q    <= agua_d;
         cafe_q    <= cafe_d;
         leche_q   <= leche_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
      end
   end

   assign valve_agua  = agua_q;
   assign valve_cafe  = cafe_q;
   assign valve_leche = leche_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fault       = fault_q;
   assign no_milk     = no_milk_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer: default timing, milk/no-milk, fault, cancel, reset, 1-cycle phases.
module tb_brew_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       cancel;
   logic [1:0] mode;

   logic agua, cafe, leche, busy, done, fault, no_milk;
   logic agua1, cafe1, leche1, busy1, done1, fault1, no_milk1;

   int checks = 0;
   int errors = 0;

   brew_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cancel      (cancel),
      .mode        (mode),
      .valve_agua  (agua),
      .valve_cafe  (cafe),
      .valve_leche (leche),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .no_milk     (no_milk)
   );

   brew_sequencer #(
      .WATER_CYCLES  (1),
      .COFFEE_CYCLES (1),
      .MILK_CYCLES   (1),
      .CNT_W         (8)
   ) dut1 (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cancel      (cancel),
      .mode        (mode),
      .valve_agua  (agua1),
      .valve_cafe  (cafe1),
      .valve_leche (leche1),
      .busy        (busy1),
      .done        (done1),
      .fault       (fault1),
      .no_milk     (no_milk1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench 1 ns after the next rising edge, i.e. inside cycle n after edge n.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] outs();
      return {agua, cafe, leche, busy, done, fault, no_milk};
   endfunction

   function automatic logic [6:0] outs1();
      return {agua1, cafe1, leche1, busy1, done1, fault1, no_milk1};
   endfunction

   // Expected {agua,cafe,leche,busy,done,fault,no_milk} in cycle n of a brew started at edge 0.
   function automatic logic [6:0] exp_out(int n, int w, int c, int m, bit milk, bit nm);
      int last;
      last = milk ? (w + c + m) : (w + c);
      return {(n >= 1 && n <= w), (n > w && n <= w + c),
              (milk && n > w + c && n <= last), (n >= 1 && n <= last + 1),
              (n == last + 1), 1'b0, nm};
   endfunction

   task automatic chk(input string tag, input int n, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %b expected %b", tag, n, got, exp);
      end
   endtask

   // Start with mode m_in at edge 0, then check cycles 1..upto; a stray start is raised in
   // cycle 5 and mode is scrambled in cycle 3, and cancel is raised in cycle cancel_at.
   task automatic run_brew(input string tag, input logic [1:0] m_in, input int upto,
                           input bit milk, input bit nm, input int cancel_at);
      mode  = m_in;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= upto; n++) begin
         step();
         chk(tag, n, outs(), exp_out(n, 8, 6, 4, milk, nm));
         start  = (n == 5);
         cancel = (n == cancel_at);
         if (n == 3) mode = ~m_in;
      end
      start  = 1'b0;
      cancel = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
      mode   = 2'b00;
      step();
      step();
      chk("reset", 0, outs(), 7'b0);
      chk("reset1", 0, outs1(), 7'b0);
      reset = 1'b1;
      step();
      chk("idle", 0, outs(), 7'b0);

      run_brew("black", 2'b01, 17, 1'b0, 1'b0, 0);
      run_brew("milk", 2'b11, 21, 1'b1, 1'b0, 0);
      // Cancel during FINISH must not suppress done.
      run_brew("nomilk", 2'b10, 17, 1'b0, 1'b1, 14);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("nomilk_sticky", i, outs(), 7'b0000001);
      end
      run_brew("nomilk_clear", 2'b01, 16, 1'b0, 1'b0, 0);

      // Zero mode: single fault pulse, nothing else moves.
      mode  = 2'b00;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("fault_pulse", 0, outs(), 7'b0000010);
      step();
      chk("fault_clear", 1, outs(), 7'b0);
      step();
      chk("fault_idle", 2, outs(), 7'b0);

      // Start together with cancel in IDLE: start wins.
      mode   = 2'b01;
      start  = 1'b1;
      cancel = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("start_cancel", n, outs(), exp_out(n, 8, 6, 4, 1'b0, 1'b0));
      end

      // Cancel seen at the edge closing cycle 10 (coffee phase).
      mode  = 2'b11;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         chk("pre_cancel", n, outs(), exp_out(n, 8, 6, 4, 1'b1, 1'b0));
      end
      cancel = 1'b1;
      for (int n = 11; n <= 22; n++) begin
         step();
         cancel = 1'b0;
         chk("cancelled", n, outs(), 7'b0);
      end

      // Reset pulse mid milk phase.
      mode  = 2'b11;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("pre_reset", n, outs(), exp_out(n, 8, 6, 4, 1'b1, 1'b0));
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_reset", 17, outs(), 7'b0);
      for (int n = 18; n <= 24; n++) begin
         step();
         chk("post_reset", n, outs(), 7'b0);
      end

      // Minimum phase lengths on the second instance.
      mode  = 2'b11;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         step();
         chk("min_phase", n, outs1(), exp_out(n, 1, 1, 1, 1'b1, 1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
